// File: rtl/sys_bus_pkg.sv
// -----------------------------------------------------------------------------
// sys_bus_pkg
// Shared definitions for system-bus initiators and monitors: initiator state
// encoding, default bus widths, response-status encoding and small helpers.
// -----------------------------------------------------------------------------
package sys_bus_pkg;

    // Default bus geometry
    localparam int unsigned SYS_AW = 32;
    localparam int unsigned SYS_DW = 32;

    // Initiator transaction phases
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } sys_bus_state_t;

    // Response status as seen by a bus master or monitor
    typedef enum logic [1:0] {
        RSP_OK   = 2'd0,
        RSP_ERR  = 2'd1,
        RSP_TOUT = 2'd2
    } sys_bus_rsp_t;

    // Collapse err/tout flags into a single status; timeout dominates
    function automatic sys_bus_rsp_t rsp_status(input logic err, input logic tout);
        if (tout) begin
            return RSP_TOUT;
        end else if (err) begin
            return RSP_ERR;
        end
        return RSP_OK;
    endfunction

    // Width of a counter able to hold 0..timeout
    function automatic int unsigned wdog_cnt_w(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/sys_bus_wdog.sv
// -----------------------------------------------------------------------------
// sys_bus_wdog
// Loadable down-counter guarding the WAIT phase of a bus transaction.
// i_start loads the counter so that o_expired_c is high during the
// TIMEOUT-th cycle after the load; the counter saturates at zero.
//
// Ports:
//   i_clk        clock
//   i_clear      synchronous clear (reset or transaction resolved)
//   i_start      load; asserted the cycle before the guarded window opens
//   o_expired_c  combinational: guarded window has reached its last cycle
// -----------------------------------------------------------------------------
module sys_bus_wdog
    import sys_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_clear,
    input  logic i_start,
    output logic o_expired_c
);

    localparam int unsigned CW = wdog_cnt_w(TIMEOUT);

    logic [CW-1:0] r_cnt;
    logic          r_active;

    // Count down the remaining window; stop once the last cycle is reached
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_cnt    <= CW'(TIMEOUT - 1);
            r_active <= 1'b1;
        end else if (r_active) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end else begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_expired_c = r_active & (r_cnt == '0);

endmodule

// File: rtl/sys_bus_initiator.sv
// -----------------------------------------------------------------------------
// sys_bus_initiator
// Issues one system-bus register read or write at a time on behalf of an
// on-chip sequencer and returns the result with error/timeout status.
//
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o      command handshake
//   cmd_we_i, cmd_addr_i,
//   cmd_wdata_i                    command payload
//   rsp_valid_o / rsp_ready_i      response handshake
//   rsp_rdata_o, rsp_err_o,
//   rsp_tout_o                     response payload
//   sys_addr_o, sys_wdata_o,
//   sys_wen_o, sys_ren_o           bus request (single-cycle strobes)
//   sys_rdata_i, sys_err_i,
//   sys_ack_i                      bus responder return
//   busy_o                         transaction in flight
// -----------------------------------------------------------------------------
module sys_bus_initiator
    import sys_bus_pkg::*;
#(
    parameter int unsigned AW      = SYS_AW,
    parameter int unsigned DW      = SYS_DW,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_we_i,
    input  logic [AW-1:0] cmd_addr_i,
    input  logic [DW-1:0] cmd_wdata_i,

    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_rdata_o,
    output logic          rsp_err_o,
    output logic          rsp_tout_o,

    output logic [AW-1:0] sys_addr_o,
    output logic [DW-1:0] sys_wdata_o,
    output logic          sys_wen_o,
    output logic          sys_ren_o,
    input  logic [DW-1:0] sys_rdata_i,
    input  logic          sys_err_i,
    input  logic          sys_ack_i,

    output logic          busy_o
);

    sys_bus_state_t r_state;
    logic           r_we;
    logic [AW-1:0]  r_sys_addr;
    logic [DW-1:0]  r_sys_wdata;
    logic           r_wen;
    logic           r_ren;
    logic           r_rsp_valid;
    logic [DW-1:0]  r_rsp_rdata;
    logic           r_rsp_err;
    logic           r_rsp_tout;
    logic           r_busy;

    logic           w_wd_start;
    logic           w_wd_clear;
    logic           w_wd_expired;

    // Watchdog is armed from REQ so its window covers exactly the WAIT cycles
    assign w_wd_start = (r_state == ST_REQ);
    assign w_wd_clear = rst_i | ((r_state == ST_WAIT) & (sys_ack_i | w_wd_expired));

    sys_bus_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .i_clk       (clk_i),
        .i_clear     (w_wd_clear),
        .i_start     (w_wd_start),
        .o_expired_c (w_wd_expired)
    );

    // Transaction FSM with registered bus and response outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_sys_addr  <= '0;
            r_sys_wdata <= '0;
            r_wen       <= 1'b0;
            r_ren       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_tout  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // Strobes last only for the REQ cycle
            r_wen <= 1'b0;
            r_ren <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        r_we        <= cmd_we_i;
                        r_sys_addr  <= cmd_addr_i;
                        r_sys_wdata <= cmd_wdata_i;
                        r_wen       <= cmd_we_i;
                        r_ren       <= ~cmd_we_i;
                        r_busy      <= 1'b1;
                        r_state     <= ST_REQ;
                    end
                end

                // Any ack seen here belongs to an earlier, abandoned access
                ST_REQ: begin
                    r_state <= ST_WAIT;
                end

                // Ack takes priority over a coincident watchdog expiry
                ST_WAIT: begin
                    if (sys_ack_i) begin
                        r_rsp_rdata <= r_we ? '0 : sys_rdata_i;
                        r_rsp_err   <= sys_err_i;
                        r_rsp_tout  <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (w_wd_expired) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_tout  <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Ready is gated by reset so nothing is accepted on a reset edge
    assign cmd_ready_o = (r_state == ST_IDLE) & ~rst_i;

    assign sys_addr_o  = r_sys_addr;
    assign sys_wdata_o = r_sys_wdata;
    assign sys_wen_o   = r_wen;
    assign sys_ren_o   = r_ren;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;
    assign rsp_tout_o  = r_rsp_tout;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_sys_bus_initiator.sv
// -----------------------------------------------------------------------------
// tb_sys_bus_initiator
// Self-checking bench: a transaction-age model predicts every output each
// cycle, and directed transactions pin key values with literal expectations.
// -----------------------------------------------------------------------------
module tb_sys_bus_initiator;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int          TO = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic          cmd_we_i = 1'b0;
    logic [AW-1:0] cmd_addr_i = '0;
    logic [DW-1:0] cmd_wdata_i = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [DW-1:0] rsp_rdata_o;
    logic          rsp_err_o;
    logic          rsp_tout_o;
    logic [AW-1:0] sys_addr_o;
    logic [DW-1:0] sys_wdata_o;
    logic          sys_wen_o;
    logic          sys_ren_o;
    logic [DW-1:0] sys_rdata_i = '0;
    logic          sys_err_i = 1'b0;
    logic          sys_ack_i = 1'b0;
    logic          busy_o;

    sys_bus_initiator #(
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_we_i    (cmd_we_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_wdata_i (cmd_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .rsp_tout_o  (rsp_tout_o),
        .sys_addr_o  (sys_addr_o),
        .sys_wdata_o (sys_wdata_o),
        .sys_wen_o   (sys_wen_o),
        .sys_ren_o   (sys_ren_o),
        .sys_rdata_i (sys_rdata_i),
        .sys_err_i   (sys_err_i),
        .sys_ack_i   (sys_ack_i),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a transaction is characterised by its age in cycles since accept.
    // Age 1 is the strobe cycle; ages 2..TO+1 are the waiting window.
    bit          m_busy = 1'b0;
    bit          m_resp = 1'b0;
    bit          m_we   = 1'b0;
    int          m_age  = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_rdata = '0;
    bit          m_err  = 1'b0;
    bit          m_tout = 1'b0;

    always @(posedge clk_i) begin
        if (rst_i) begin
            m_busy  <= 1'b0;
            m_resp  <= 1'b0;
            m_we    <= 1'b0;
            m_age   <= 0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_rdata <= '0;
            m_err   <= 1'b0;
            m_tout  <= 1'b0;
        end else if (!m_busy) begin
            if (cmd_valid_i) begin
                m_busy  <= 1'b1;
                m_age   <= 1;
                m_we    <= cmd_we_i;
                m_addr  <= cmd_addr_i;
                m_wdata <= cmd_wdata_i;
            end
        end else if (m_resp) begin
            if (rsp_ready_i) begin
                m_busy <= 1'b0;
                m_resp <= 1'b0;
                m_age  <= 0;
            end
        end else if (m_age == 1) begin
            m_age <= 2;
        end else if (sys_ack_i) begin
            m_resp  <= 1'b1;
            m_rdata <= m_we ? 32'h0 : sys_rdata_i;
            m_err   <= sys_err_i;
            m_tout  <= 1'b0;
        end else if (m_age == TO + 1) begin
            m_resp  <= 1'b1;
            m_rdata <= 32'h0;
            m_err   <= 1'b1;
            m_tout  <= 1'b1;
        end else begin
            m_age <= m_age + 1;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the clock edge
    always @(negedge clk_i) begin
        if (cmp_en) begin
            check1("cmd_ready", cmd_ready_o, !m_busy && !rst_i);
            check1("sys_wen", sys_wen_o, m_busy && !m_resp && m_age == 1 && m_we);
            check1("sys_ren", sys_ren_o, m_busy && !m_resp && m_age == 1 && !m_we);
            check1("busy", busy_o, m_busy);
            check1("rsp_valid", rsp_valid_o, m_resp);
            check32("sys_addr", sys_addr_o, m_addr);
            check32("sys_wdata", sys_wdata_o, m_wdata);
            if (m_resp) begin
                check32("rsp_rdata", rsp_rdata_o, m_rdata);
                check1("rsp_err", rsp_err_o, m_err);
                check1("rsp_tout", rsp_tout_o, m_tout);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One transaction. ack_wait = waiting cycle (1-based) carrying the ack,
    // 0 = silent responder. stale_ack drives an ack during the strobe cycle.
    // hold = cycles of response backpressure; bp_valid presents a read of
    // 0x3C throughout the backpressure.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_wait, input logic [31:0] ack_rdata, input logic ack_err,
                           input bit stale_ack, input int hold, input bit bp_valid,
                           output logic [31:0] o_rdata, output logic o_err, output logic o_tout,
                           output int o_lat);
        int n;
        o_rdata = 'x;
        o_err   = 1'bx;
        o_tout  = 1'bx;
        o_lat   = -1;
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_addr_i  = addr;
        cmd_wdata_i = wdata;
        n = 0;
        while (!cmd_ready_o && n < 50) begin
            tick();
            n++;
        end
        if (!cmd_ready_o) begin
            check1("accept_bound", 1'b0, 1'b1);
            cmd_valid_i = 1'b0;
            return;
        end
        tick();
        cmd_valid_i = 1'b0;
        check1("strobe_wen", sys_wen_o, we);
        check1("strobe_ren", sys_ren_o, !we);
        if (stale_ack) begin
            sys_ack_i   = 1'b1;
            sys_err_i   = 1'b1;
            sys_rdata_i = 32'hDEAD_BEEF;
        end
        tick();
        sys_ack_i   = 1'b0;
        sys_err_i   = 1'b0;
        sys_rdata_i = '0;
        o_lat = 2;
        for (int w = 1; w <= TO; w++) begin
            if (w == ack_wait) begin
                sys_ack_i   = 1'b1;
                sys_err_i   = ack_err;
                sys_rdata_i = ack_rdata;
            end
            tick();
            o_lat++;
            sys_ack_i   = 1'b0;
            sys_err_i   = 1'b0;
            sys_rdata_i = '0;
            if (w == ack_wait) break;
        end
        n = 0;
        while (!rsp_valid_o && n < 20) begin
            tick();
            o_lat++;
            n++;
        end
        if (!rsp_valid_o) begin
            check1("rsp_bound", 1'b0, 1'b1);
            return;
        end
        o_rdata = rsp_rdata_o;
        o_err   = rsp_err_o;
        o_tout  = rsp_tout_o;
        for (int h = 0; h < hold; h++) begin
            if (bp_valid) begin
                cmd_valid_i = 1'b1;
                cmd_we_i    = 1'b0;
                cmd_addr_i  = 32'h0000_003C;
                cmd_wdata_i = '0;
            end
            tick();
            check1("bp_valid_held", rsp_valid_o, 1'b1);
            check32("bp_rdata_held", rsp_rdata_o, o_rdata);
            check1("bp_err_held", rsp_err_o, o_err);
            check1("bp_cmd_ready", cmd_ready_o, 1'b0);
            check1("bp_no_strobe", sys_wen_o | sys_ren_o, 1'b0);
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        tt;
        int          lat;

        rst_i = 1'b1;
        tick();
        cmp_en = 1'b1;
        tick();
        check1("rst_cmd_ready", cmd_ready_o, 1'b0);
        check1("rst_busy", busy_o, 1'b0);
        check1("rst_rsp_valid", rsp_valid_o, 1'b0);
        check32("rst_sys_addr", sys_addr_o, 32'h0);
        check32("rst_rsp_rdata", rsp_rdata_o, 32'h0);
        rst_i = 1'b0;
        #1;
        check1("idle_cmd_ready", cmd_ready_o, 1'b1);
        tick();

        // Write; responder returns garbage rdata that must be discarded
        run_txn(1'b1, 32'h14, 32'h0000_1234, 1, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 1'b0, rd, er, tt, lat);
        check32("wr_rdata", rd, 32'h0);
        check1("wr_err", er, 1'b0);
        check1("wr_tout", tt, 1'b0);
        check_int("wr_latency", lat, 3);
        check32("wr_addr_held", sys_addr_o, 32'h14);
        check32("wr_wdata_held", sys_wdata_o, 32'h0000_1234);

        // Read back
        run_txn(1'b0, 32'h14, 32'h0, 1, 32'h0000_1234, 1'b0, 1'b0, 0, 1'b0, rd, er, tt, lat);
        check32("rd_rdata", rd, 32'h0000_1234);
        check1("rd_err", er, 1'b0);
        check_int("rd_latency", lat, 3);

        // Silent responder
        run_txn(1'b0, 32'h20, 32'h0, 0, 32'h0, 1'b0, 1'b0, 0, 1'b0, rd, er, tt, lat);
        check32("to_rdata", rd, 32'h0);
        check1("to_err", er, 1'b1);
        check1("to_tout", tt, 1'b1);
        check_int("to_latency", lat, TO + 2);

        // Late ack lands in the next transaction's strobe cycle and is ignored
        run_txn(1'b0, 32'h24, 32'h0, 2, 32'hCAFE_0024, 1'b0, 1'b1, 0, 1'b0, rd, er, tt, lat);
        check32("late_rdata", rd, 32'hCAFE_0024);
        check1("late_err", er, 1'b0);
        check_int("late_latency", lat, 4);

        // Ack on the final waiting cycle beats the timeout
        run_txn(1'b1, 32'h30, 32'h0000_0030, TO, 32'h0, 1'b0, 1'b0, 0, 1'b0, rd, er, tt, lat);
        check1("edge_err", er, 1'b0);
        check1("edge_tout", tt, 1'b0);
        check_int("edge_latency", lat, TO + 2);

        // Backpressure with a waiting command
        run_txn(1'b0, 32'h38, 32'h0, 1, 32'h3838_3838, 1'b0, 1'b0, 10, 1'b1, rd, er, tt, lat);
        check32("bp_rdata", rd, 32'h3838_3838);
        check1("bp_ready_after", cmd_ready_o, 1'b1);
        run_txn(1'b0, 32'h3C, 32'h0, 1, 32'h3C3C_3C3C, 1'b0, 1'b0, 0, 1'b0, rd, er, tt, lat);
        check32("bp_next_rdata", rd, 32'h3C3C_3C3C);
        check_int("bp_next_latency", lat, 3);

        // Responder error on a read still returns its data
        run_txn(1'b0, 32'h50, 32'h0, 1, 32'h5050_0BAD, 1'b1, 1'b0, 0, 1'b0, rd, er, tt, lat);
        check32("err_rdata", rd, 32'h5050_0BAD);
        check1("err_err", er, 1'b1);
        check1("err_tout", tt, 1'b0);

        // Reset during the waiting window drops the transaction
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b1;
        cmd_addr_i  = 32'h60;
        cmd_wdata_i = 32'h6060_6060;
        tick();
        cmd_valid_i = 1'b0;
        tick();
        tick();
        check1("pre_rst_busy", busy_o, 1'b1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check1("mid_rst_busy", busy_o, 1'b0);
        check1("mid_rst_valid", rsp_valid_o, 1'b0);
        check1("mid_rst_strobe", sys_wen_o | sys_ren_o, 1'b0);
        check32("mid_rst_addr", sys_addr_o, 32'h0);
        for (int i = 0; i < 4; i++) begin
            sys_ack_i = (i == 1);
            tick();
            check1("post_rst_no_rsp", rsp_valid_o, 1'b0);
        end
        sys_ack_i = 1'b0;
        run_txn(1'b0, 32'h64, 32'h0, 1, 32'h6464_0001, 1'b0, 1'b0, 0, 1'b0, rd, er, tt, lat);
        check32("post_rst_rdata", rd, 32'h6464_0001);
        check1("post_rst_err", er, 1'b0);
        check_int("post_rst_latency", lat, 3);

        tick();
        tick();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
